// File: rtl/game_pkg.sv
// Shared game codes: FSM state encoding, player symbol codes and checker error codes.
// The string writer and display decoder use the same symbol codes.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKIP    = 3'd1,
        ST_DECODE  = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_PASS    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [2:0] SYM_NONE   = 3'd0;
    localparam logic [2:0] SYM_TOGGLE = 3'd1;
    localparam logic [2:0] SYM_PUSH   = 3'd2;
    localparam logic [2:0] SYM_MIC    = 3'd3;
    localparam logic [2:0] SYM_MOUSE  = 3'd4;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_MISMATCH  = 2'd1;
    localparam logic [1:0] ERR_MALFORMED = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    // A run of ones names a symbol only when it is toggle..mouse.
    function automatic logic is_symbol_run(input logic [2:0] run);
        return (run >= SYM_TOGGLE) && (run <= SYM_MOUSE);
    endfunction

endpackage

// File: rtl/symbol_extractor.sv
// Shift register and run counter that walk a unary-coded symbol string MSB first.
// Zeros are shifted in from the bottom, so the register always drains to empty.
module symbol_extractor #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] pattern,
    input  logic         shift,
    input  logic         run_inc,
    input  logic         run_clr,
    output logic         empty,
    output logic         msb,
    output logic [2:0]   run_count
);

    logic [W-1:0] shift_reg;
    logic [2:0]   run_count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg     <= '0;
            run_count_reg <= 3'd0;
        end else if (load) begin
            shift_reg     <= pattern;
            run_count_reg <= 3'd0;
        end else begin
            if (shift)
                shift_reg <= {shift_reg[W-2:0], 1'b0};
            // Saturate so an overlong run still reads as malformed.
            if (run_clr)
                run_count_reg <= 3'd0;
            else if (run_inc && (run_count_reg != 3'd7))
                run_count_reg <= run_count_reg + 3'd1;
        end
    end

    assign empty     = (shift_reg == '0);
    assign msb       = shift_reg[W-1];
    assign run_count = run_count_reg;

endmodule

// File: rtl/sequence_checker.sv
// Replays a unary-coded symbol string and checks player inputs against it.
// Define SEQUENCE_CHECKER_TIMEOUT_EN to fail after TIMEOUT idle cycles in WAIT_IN.
module sequence_checker
    import game_pkg::*;
#(
    parameter int          W       = 64,
    parameter logic [25:0] TIMEOUT = 26'd200
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] pattern,
    input  logic         in_valid,
    input  logic [2:0]   in_code,
    output logic         ready,
    output logic [2:0]   expected,
    output logic         pass,
    output logic         fail,
    output logic [1:0]   err,
    output logic [5:0]   score
);

    state_t     state_reg;
    logic [2:0] expected_reg;
    logic [1:0] err_reg;
    logic [5:0] score_reg;

    logic       ext_shift;
    logic       ext_run_inc;
    logic       ext_run_clr;
    logic       ext_empty;
    logic       ext_msb;
    logic [2:0] ext_run_count;
    logic       input_match;

`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    logic [25:0] timer_reg;
`else
    localparam logic [25:0] timeout_unused = TIMEOUT;
`endif

    symbol_extractor #(.W(W)) u_extractor (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .pattern   (pattern),
        .shift     (ext_shift),
        .run_inc   (ext_run_inc),
        .run_clr   (ext_run_clr),
        .empty     (ext_empty),
        .msb       (ext_msb),
        .run_count (ext_run_count)
    );

    assign input_match = (in_code == expected_reg);

    // Extractor commands follow the registered state; load overrides them inside the extractor.
    always_comb begin
        ext_shift   = 1'b0;
        ext_run_inc = 1'b0;
        ext_run_clr = 1'b0;
        case (state_reg)
            ST_SKIP: begin
                ext_shift = !ext_empty && !ext_msb;
            end
            ST_DECODE: begin
                ext_shift   = 1'b1;
                ext_run_inc = ext_msb;
            end
            ST_WAIT_IN: begin
                ext_run_clr = in_valid && input_match;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            expected_reg <= SYM_NONE;
            err_reg      <= ERR_NONE;
            score_reg    <= 6'd0;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
            timer_reg    <= 26'd0;
`endif
        end else if (load) begin
            state_reg    <= ST_SKIP;
            expected_reg <= SYM_NONE;
            err_reg      <= ERR_NONE;
            score_reg    <= 6'd0;
        end else begin
            case (state_reg)
                ST_SKIP: begin
                    if (ext_empty)
                        state_reg <= ST_PASS;
                    else if (ext_msb)
                        state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    // A zero at the MSB is the terminator; the run is complete.
                    if (!ext_msb) begin
                        if (is_symbol_run(ext_run_count)) begin
                            expected_reg <= ext_run_count;
                            state_reg    <= ST_WAIT_IN;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
                            timer_reg    <= TIMEOUT;
`endif
                        end else begin
                            err_reg   <= ERR_MALFORMED;
                            state_reg <= ST_FAIL;
                        end
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        expected_reg <= SYM_NONE;
                        if (input_match) begin
                            score_reg <= score_reg + 6'd1;
                            state_reg <= ext_empty ? ST_PASS : ST_DECODE;
                        end else begin
                            err_reg   <= ERR_MISMATCH;
                            state_reg <= ST_FAIL;
                        end
                    end
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
                    else if (timer_reg <= 26'd1) begin
                        timer_reg    <= 26'd0;
                        expected_reg <= SYM_NONE;
                        err_reg      <= ERR_TIMEOUT;
                        state_reg    <= ST_FAIL;
                    end else begin
                        timer_reg <= timer_reg - 26'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign ready    = (state_reg == ST_WAIT_IN);
    assign pass     = (state_reg == ST_PASS);
    assign fail     = (state_reg == ST_FAIL);
    assign expected = expected_reg;
    assign err      = err_reg;
    assign score    = score_reg;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: pass, mismatch, malformed, empty, full, reload, reset, timeout.
module tb_sequence_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [63:0] pattern = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_code = 3'd0;
    logic        ready;
    logic [2:0]  expected;
    logic        pass;
    logic        fail;
    logic [1:0]  err;
    logic [5:0]  score;

    int passed = 0;
    int total  = 0;

`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    sequence_checker #(.W(64), .TIMEOUT(26'd10)) dut (
`else
    sequence_checker #(.W(64)) dut (
`endif
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .pattern  (pattern),
        .in_valid (in_valid),
        .in_code  (in_code),
        .ready    (ready),
        .expected (expected),
        .pass     (pass),
        .fail     (fail),
        .err      (err),
        .score    (score)
    );

    always #5 clock = ~clock;

    // All drivers below start and end on a falling edge.
    task automatic do_load(input logic [63:0] p);
        pattern = p;
        load    = 1'b1;
        @(negedge clock);
        load    = 1'b0;
        $display("load pattern=%h score=%0d ready=%0b", p, score, ready);
    endtask

    task automatic wait_ready(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (!ready && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        ok = ready;
    endtask

    task automatic send(input logic [2:0] c);
        in_code  = c;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        $display("input code=%0d -> ready=%0b score=%0d pass=%0b err=%0d", c, ready, score, pass, err);
    endtask

    task automatic test_reset;
        logic [13:0] outs;
        @(negedge clock);
        outs = {ready, expected, pass, fail, err, score};
        total++;
        if (outs !== 14'd0) $display("FAIL reset_outputs: got %h want 0", outs);
        else passed++;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        outs = {ready, expected, pass, fail, err, score};
        total++;
        if (outs !== 14'd0) $display("FAIL reset_idle: got %h want 0", outs);
        else passed++;
        $display("reset released, outputs=%h", outs);
    endtask

    task automatic test_two_symbol;
        int cyc;
        bit ok;
        do_load(64'h16);
        wait_ready(200, cyc, ok);
        total++;
        if (!ok || cyc != 62) $display("FAIL two_first_ready: got ok=%0b cycles=%0d want ok=1 cycles=62", ok, cyc);
        else passed++;
        total++;
        if (expected !== 3'd1) $display("FAIL two_exp1: got %0d want 1", expected);
        else passed++;
        send(3'd1);
        total++;
        if (ready !== 1'b0 || score !== 6'd1) $display("FAIL two_after1: got ready=%0b score=%0d want ready=0 score=1", ready, score);
        else passed++;
        wait_ready(20, cyc, ok);
        total++;
        if (!ok || cyc != 3 || expected !== 3'd2) $display("FAIL two_exp2: got ok=%0b cycles=%0d exp=%0d want ok=1 cycles=3 exp=2", ok, cyc, expected);
        else passed++;
        send(3'd2);
        total++;
        if (pass !== 1'b1 || fail !== 1'b0 || score !== 6'd2 || err !== 2'd0 || expected !== 3'd0)
            $display("FAIL two_pass: got pass=%0b fail=%0b score=%0d err=%0d exp=%0d want 1 0 2 0 0", pass, fail, score, err, expected);
        else passed++;
    endtask

    task automatic test_mismatch;
        int cyc;
        bit ok;
        do_load(64'h16);
        wait_ready(200, cyc, ok);
        total++;
        if (!ok) $display("FAIL mis_ready: got 0 want 1");
        else passed++;
        send(3'd3);
        total++;
        if (fail !== 1'b1 || err !== 2'd1 || score !== 6'd0 || pass !== 1'b0)
            $display("FAIL mis_result: got fail=%0b err=%0d score=%0d pass=%0b want 1 1 0 0", fail, err, score, pass);
        else passed++;
        send(3'd1);
        repeat (3) @(negedge clock);
        total++;
        if (fail !== 1'b1 || err !== 2'd1 || score !== 6'd0 || ready !== 1'b0)
            $display("FAIL mis_sticky: got fail=%0b err=%0d score=%0d ready=%0b want 1 1 0 0", fail, err, score, ready);
        else passed++;
    endtask

    task automatic test_malformed;
        int  cyc;
        bit  saw_ready;
        do_load(64'h3E);
        cyc = 0;
        saw_ready = 1'b0;
        while (!fail && cyc < 200) begin
            saw_ready |= ready;
            @(negedge clock);
            cyc++;
        end
        $display("malformed pattern settled after %0d cycles", cyc);
        total++;
        if (fail !== 1'b1 || err !== 2'd2 || saw_ready || score !== 6'd0)
            $display("FAIL malformed: got fail=%0b err=%0d ready_seen=%0b score=%0d want 1 2 0 0", fail, err, saw_ready, score);
        else passed++;
    endtask

    task automatic test_empty;
        do_load(64'h0);
        total++;
        if (pass !== 1'b0 || fail !== 1'b0) $display("FAIL empty_in_skip: got pass=%0b fail=%0b want 0 0", pass, fail);
        else passed++;
        @(negedge clock);
        total++;
        if (pass !== 1'b1 || score !== 6'd0 || err !== 2'd0) $display("FAIL empty_pass: got pass=%0b score=%0d err=%0d want 1 0 0", pass, score, err);
        else passed++;
    endtask

    task automatic test_full;
        int cyc;
        bit ok;
        int bad = 0;
        do_load(64'hAAAA_AAAA_AAAA_AAAA);
        for (int i = 0; i < 32; i++) begin
            wait_ready(20, cyc, ok);
            total++;
            if (!ok || expected !== 3'd1) begin
                $display("FAIL full_sym%0d: got ok=%0b exp=%0d want ok=1 exp=1", i, ok, expected);
                bad++;
            end else passed++;
            if (bad > 3) break;
            send(3'd1);
        end
        total++;
        if (pass !== 1'b1 || score !== 6'd32 || err !== 2'd0) $display("FAIL full_pass: got pass=%0b score=%0d err=%0d want 1 32 0", pass, score, err);
        else passed++;
    endtask

    task automatic test_reload;
        int cyc;
        bit ok;
        do_load(64'h16);
        wait_ready(200, cyc, ok);
        send(3'd1);
        wait_ready(20, cyc, ok);
        total++;
        if (!ok || score !== 6'd1 || expected !== 3'd2) $display("FAIL reload_pre: got ok=%0b score=%0d exp=%0d want 1 1 2", ok, score, expected);
        else passed++;
        // Load collides with a matching input; the input must be dropped.
        pattern  = 64'h2;
        load     = 1'b1;
        in_valid = 1'b1;
        in_code  = 3'd2;
        @(negedge clock);
        load     = 1'b0;
        in_valid = 1'b0;
        $display("load+input pattern=%h -> score=%0d ready=%0b", pattern, score, ready);
        total++;
        if (score !== 6'd0 || ready !== 1'b0 || pass !== 1'b0) $display("FAIL reload_clear: got score=%0d ready=%0b pass=%0b want 0 0 0", score, ready, pass);
        else passed++;
        wait_ready(200, cyc, ok);
        total++;
        if (!ok || cyc != 65 || expected !== 3'd1) $display("FAIL reload_ready: got ok=%0b cycles=%0d exp=%0d want 1 65 1", ok, cyc, expected);
        else passed++;
        send(3'd1);
        total++;
        if (pass !== 1'b1 || score !== 6'd1) $display("FAIL reload_pass: got pass=%0b score=%0d want 1 1", pass, score);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit ok;
        logic [13:0] outs;
        do_load(64'h16);
        wait_ready(200, cyc, ok);
        send(3'd1);
        total++;
        if (score !== 6'd1 || ready !== 1'b0) $display("FAIL rstmid_pre: got score=%0d ready=%0b want 1 0", score, ready);
        else passed++;
        #2 reset = 1'b1;
        #1 outs = {ready, expected, pass, fail, err, score};
        $display("reset asserted mid-decode -> outputs=%h", outs);
        total++;
        if (outs !== 14'd0) $display("FAIL rstmid_async: got %h want 0", outs);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        repeat (80) @(negedge clock);
        outs = {ready, expected, pass, fail, err, score};
        total++;
        if (outs !== 14'd0) $display("FAIL rstmid_idle: got %h want 0", outs);
        else passed++;
    endtask

    task automatic test_timeout;
        int cyc;
        bit ok;
        do_load(64'h2);
        wait_ready(200, cyc, ok);
        total++;
        if (!ok) $display("FAIL to_ready: got 0 want 1");
        else passed++;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
        cyc = 0;
        while (!fail && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        $display("timeout observed after %0d cycles", cyc);
        total++;
        if (fail !== 1'b1 || err !== 2'd3 || cyc != 10) $display("FAIL to_expire: got fail=%0b err=%0d cycles=%0d want 1 3 10", fail, err, cyc);
        else passed++;
`else
        repeat (1000) @(negedge clock);
        $display("idle 1000 cycles in wait -> ready=%0b fail=%0b err=%0d", ready, fail, err);
        total++;
        if (ready !== 1'b1 || fail !== 1'b0 || err !== 2'd0 || expected !== 3'd1)
            $display("FAIL to_wait: got ready=%0b fail=%0b err=%0d exp=%0d want 1 0 0 1", ready, fail, err, expected);
        else passed++;
`endif
    endtask

    initial begin
        test_reset;
        test_two_symbol;
        test_mismatch;
        test_malformed;
        test_empty;
        test_full;
        test_reload;
        test_reset_mid;
        test_timeout;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
